// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu.
// Contents:
//   - ALUControl opcode values (the legacy AND/OR/ADD/SUB codes are unchanged)
//   - FSM state encoding
//   - opcode classification helpers
package alu_pkg;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpRsvd = 4'b1011;
    localparam logic [3:0] OpDivu = 4'b1100;
    localparam logic [3:0] OpRemu = 4'b1101;
    localparam logic [3:0] OpDiv  = 4'b1110;
    localparam logic [3:0] OpRem  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // MUL and the four divide/remainder ops run through the iterative unit.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OpMul) || (op[3:2] == 2'b11);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OpRemu) || (op == OpRem);
    endfunction

endpackage

// File: rtl/iter_alu_muldiv_iter.sv
// muldiv_iter: radix-2 iterative multiplier / restoring divider.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   flush       abandon the operation in flight
//   start       latch op/a/b and begin WIDTH steps
//   op          ALUControl code (MUL, DIVU, REMU, DIV, REM)
//   a, b        operands (a = multiplicand / dividend, b = multiplier / divisor)
//   busy        an operation is in flight
//   done        high during the final step; result is valid in that cycle
//   result      final value, including sign fix-up for signed divide/remainder
// Divide-by-zero and signed overflow are resolved by the parent and never started here.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    // Shared working registers:
    //   MUL: r_a = partial product, r_b = shifted multiplicand, r_c = remaining multiplier
    //   DIV: r_a = partial remainder, r_b = divisor magnitude, r_c = dividend/quotient shifter
    logic [WIDTH-1:0] r_a_q, r_a_d;
    logic [WIDTH-1:0] r_b_q, r_b_d;
    logic [WIDTH-1:0] r_c_q, r_c_d;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             is_mul_q;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Magnitudes for signed division; -MIN wraps to MIN, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = is_signed_div(op) & a[WIDTH-1];
        b_neg = is_signed_div(op) & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        shifted = {r_a_q, r_c_q[WIDTH-1]};
        // Top bit set means borrow: divisor does not fit, restore the shifted remainder.
        diff    = shifted - {1'b0, r_b_q};
        if (is_mul_q) begin
            r_a_d = r_a_q + (r_c_q[0] ? r_b_q : '0);
            r_b_d = r_b_q << 1;
            r_c_d = r_c_q >> 1;
        end else begin
            r_a_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            r_b_d = r_b_q;
            r_c_d = {r_c_q[WIDTH-2:0], ~diff[WIDTH]};
        end

        if (is_mul_q) begin
            result = r_a_d;
        end else if (is_rem_q) begin
            result = neg_rem_q ? -r_a_d : r_a_d;
        end else begin
            result = neg_quo_q ? -r_c_d : r_c_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_c_q     <= '0;
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_mul_q  <= (op == OpMul);
            is_rem_q  <= is_rem_op(op);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            r_a_q     <= '0;
            if (op == OpMul) begin
                r_b_q <= a;
                r_c_q <= b;
            end else begin
                r_b_q <= b_mag;
                r_c_q <= a_mag;
            end
        end else if (busy_q) begin
            r_a_q <= r_a_d;
            r_b_q <= r_b_d;
            r_c_q <= r_c_d;
            if (cnt_q == LastStep) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LastStep);

endmodule

// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with single-cycle logic/shift/compare ops and
// iterative MUL/DIV/REM (RV64M-style results).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operation handshake; X, Y, ALUControl sampled on acceptance only
//   X, Y                  operands (Y also divisor / shift amount)
//   ALUControl            operation select
//   flush                 abort anything in flight; blocks acceptance while high
//   out_valid / out_ready result handshake
//   ALUResult, Zero       registered result and its zero flag
// Simple ops, divide-by-zero, signed overflow and the reserved code finish in one cycle;
// MUL/DIV/REM otherwise take WIDTH+1 cycles.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       ALUControl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             div_zero;
    logic             div_ovf;
    logic             use_iter;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] quick;

    // md_busy is only ever high in BUSY; folding it in keeps the handshake safe if that changes.
    assign in_ready  = (state_q == IDLE) && !md_busy;
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready && in_valid && !flush;

    assign div_zero  = is_div_op(ALUControl) && (Y == '0);
    assign div_ovf   = is_signed_div(ALUControl) && (X == MinNeg) && (Y == '1);
    assign use_iter  = is_iterative(ALUControl) && !div_zero && !div_ovf;
    assign shamt     = Y[SHAMT_W-1:0];

    // Single-cycle results, including the divide corner cases that skip iteration.
    always_comb begin
        quick = '0;
        unique case (ALUControl)
            OpAnd:  quick = X & Y;
            OpOr:   quick = X | Y;
            OpAdd:  quick = X + Y;
            OpSub:  quick = X - Y;
            OpXor:  quick = X ^ Y;
            OpSll:  quick = X << shamt;
            OpSrl:  quick = X >> shamt;
            OpSra:  quick = $unsigned($signed(X) >>> shamt);
            OpSlt:  quick = {{(WIDTH - 1){1'b0}}, $signed(X) < $signed(Y)};
            OpSltu: quick = {{(WIDTH - 1){1'b0}}, X < Y};
            OpDivu, OpDiv: begin
                if (div_zero) begin
                    quick = '1;
                end else if (div_ovf) begin
                    quick = X;
                end
            end
            OpRemu, OpRem: begin
                if (div_zero) begin
                    quick = X;
                end
            end
            default: quick = '0;  // MUL (iterative) and the reserved code
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        md_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (use_iter) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        result_d = quick;
                        zero_d   = (quick == '0);
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (md_done) begin
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (md_start),
        .op    (ALUControl),
        .a     (X),
        .b     (Y),
        .busy  (md_busy),
        .done  (md_done),
        .result(md_result)
    );

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
`timescale 1ns/1ps
module tb_iter_alu;

    localparam logic [3:0] AND = 4'h0, OR = 4'h1, ADD = 4'h2, XOR = 4'h3, SLL = 4'h4;
    localparam logic [3:0] SUB = 4'h6, SRA = 4'h7, SLT = 4'h8, SLTU = 4'h9, MUL = 4'hA;
    localparam logic [3:0] DIVU = 4'hC, REM = 4'hF, DIV = 4'hE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, Zero;
    logic [63:0] X, Y, ALUResult;
    logic [3:0]  ALUControl;

    logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8, zero8;
    logic [7:0]  x8, y8, res8;
    logic [3:0]  ctl8;

    iter_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
        .ALUControl(ALUControl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .X(x8), .Y(y8),
        .ALUControl(ctl8), .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
        .ALUResult(res8), .Zero(zero8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint sext(input logic [63:0] v, input int w);
        logic [63:0] m;
        logic [63:0] t;
        m = wmask(w);
        t = v & m;
        return t[w-1] ? longint'(t | ~m) : longint'(t);
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] xi,
                                            input logic [63:0] yi, input int w);
        logic [63:0] m, x, y, r;
        longint sx, sy, smin;
        int sh;
        m    = wmask(w);
        x    = xi & m;
        y    = yi & m;
        sx   = sext(x, w);
        sy   = sext(y, w);
        smin = -(longint'(1) << (w - 1));
        sh   = int'(y & 64'(w - 1));
        case (op)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: r = x + y;
            4'h3: r = x ^ y;
            4'h4: r = x << sh;
            4'h5: r = x >> sh;
            4'h6: r = x - y;
            4'h7: r = 64'(sx >>> sh);
            4'h8: r = (sx < sy) ? 64'd1 : 64'd0;
            4'h9: r = (x < y) ? 64'd1 : 64'd0;
            4'hA: r = x * y;
            4'hC: r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
            4'hD: r = (y == 0) ? x : x % y;
            4'hE: r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                      (sx == smin && sy == -1) ? x : 64'(sx / sy);
            4'hF: r = (y == 0) ? x : (sx == smin && sy == -1) ? 64'd0 : 64'(sx % sy);
            default: r = 64'd0;
        endcase
        return r & m;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] xi,
                                   input logic [63:0] yi, input int w);
        logic [63:0] y;
        y = yi & wmask(w);
        if (op == 4'hA) return w + 1;
        if (op >= 4'hC) begin
            if (y == 0) return 1;
            if (op >= 4'hE && sext(xi, w) == -(longint'(1) << (w - 1)) && sext(y, w) == -1)
                return 1;
            return w + 1;
        end
        return 1;
    endfunction

    // Protocol tracker for the 64-bit instance: counts down to the result, then holds it.
    bit          m_busy = 0, m_hold = 0;
    int          m_left = 0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_hold <= 0;
        end else if (flush) begin
            m_busy <= 0;
            m_hold <= 0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 0;
                m_hold <= 1;
            end
            m_left <= m_left - 1;
        end else if (in_valid) begin
            m_res <= ref_alu(ALUControl, X, Y, 64);
            if (ref_lat(ALUControl, X, Y, 64) == 1) begin
                m_hold <= 1;
            end else begin
                m_busy <= 1;
                m_left <= ref_lat(ALUControl, X, Y, 64) - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("out_valid", 64'(out_valid), 64'(m_hold));
            check("in_ready", 64'(in_ready), 64'(!(m_busy || m_hold)));
            if (m_hold) begin
                check("ALUResult", ALUResult, m_res);
                check("Zero", 64'(Zero), 64'(m_res == 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 15));
            1: return 64'd0;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input bit w8, input bit v, input logic [3:0] op,
                         input logic [63:0] x, input logic [63:0] y);
        if (w8) begin
            in_valid8 = v; ctl8 = op; x8 = x[7:0]; y8 = y[7:0];
        end else begin
            in_valid = v; ALUControl = op; X = x; Y = y;
        end
    endtask

    // Issue one op to an idle instance (called at a negedge, out_ready=1) and measure latency.
    task automatic run_op(input bit w8, input bit pin, input string name, input logic [3:0] op,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp, input int exp_lat);
        int cyc;
        logic ov;
        int w;
        w = w8 ? 8 : 64;
        if (pin) begin
            check({name, " model"}, ref_alu(op, x, y, w), exp);
            check({name, " model latency"}, 64'(ref_lat(op, x, y, w)), 64'(exp_lat));
        end
        drive(w8, 1'b1, op, x, y);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(w8, 1'b0, 4'($urandom), rnd_operand(), rnd_operand());
            ov = w8 ? out_valid8 : out_valid;
            if (!ov) check({name, " in_ready while busy"}, 64'(w8 ? in_ready8 : in_ready), 64'd0);
        end while (!ov && cyc < 200);
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " result"}, w8 ? 64'(res8) : ALUResult, exp);
        check({name, " zero"}, 64'(w8 ? zero8 : Zero), 64'(exp == 0));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 0; flush = 0; out_ready = 1; X = '0; Y = '0; ALUControl = '0;
        in_valid8 = 0; flush8 = 0; out_ready8 = 1; x8 = '0; y8 = '0; ctl8 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset ALUResult", ALUResult, 64'd0);
        check("reset Zero", 64'(Zero), 64'd0);
        #20 rst_n = 1'b1;
        @(negedge clk);

        // Regression and iterative directed cases (64-bit)
        run_op(0, 1, "AND", AND, 64'd7, 64'd4, 64'd4, 1);
        run_op(0, 1, "OR", OR, 64'd7, 64'd8, 64'd15, 1);
        run_op(0, 1, "ADD", ADD, 64'd10, 64'd23, 64'd33, 1);
        run_op(0, 1, "SUB neg", SUB, 64'd15, 64'd18, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        run_op(0, 1, "SUB zero", SUB, 64'd5, 64'd5, 64'd0, 1);
        run_op(0, 1, "XOR", XOR, 64'hF0F0, 64'h0FF0, 64'hFF00, 1);
        run_op(0, 1, "SLT", SLT, -64'd1, 64'd1, 64'd1, 1);
        run_op(0, 1, "MUL", MUL, 64'd6, 64'd7, 64'd42, 65);
        run_op(0, 1, "DIV", DIV, -64'd7, 64'd2, -64'd3, 65);
        run_op(0, 1, "REM", REM, -64'd7, 64'd2, -64'd1, 65);
        run_op(0, 1, "DIVU", DIVU, 64'd100, 64'd7, 64'd14, 65);
        run_op(0, 1, "DIVU by 0", DIVU, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op(0, 1, "REM by 0", REM, 64'd9, 64'd0, 64'd9, 1);
        run_op(0, 1, "DIV ovf", DIV, 64'h8000_0000_0000_0000, -64'd1,
               64'h8000_0000_0000_0000, 1);

        // Backpressure
        out_ready = 0;
        drive(0, 1, ADD, 64'd1, 64'd1);
        @(negedge clk);
        drive(0, 0, MUL, 64'd3, 64'd3);
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp result", ALUResult, 64'd2);
            check("bp in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);

        // Flush during DIV
        begin
            int seen;
            seen = 0;
            drive(0, 1, DIV, 64'd100, 64'd7);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i == 0) drive(0, 0, ADD, 64'd0, 64'd0);
            end
            flush = 1;
            @(negedge clk);
            flush = 0;
            check("flush out_valid", 64'(out_valid), 64'd0);
            check("flush in_ready", 64'(in_ready), 64'd1);
            for (int i = 0; i < 70; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("flush no result pulse", 64'(seen), 64'd0);
        end
        run_op(0, 1, "SLL", SLL, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1);

        // Reset mid-MUL
        drive(0, 1, MUL, 64'd6, 64'd7);
        @(negedge clk);
        drive(0, 0, ADD, 64'd0, 64'd0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", 64'(out_valid), 64'd0);
        check("mid-reset in_ready", 64'(in_ready), 64'd1);
        check("mid-reset ALUResult", ALUResult, 64'd0);
        check("mid-reset Zero", 64'(Zero), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 1, "MUL after reset", MUL, 64'd6, 64'd7, 64'd42, 65);

        // WIDTH=8 instance
        run_op(1, 1, "SRA8", SRA, 64'h80, 64'd3, 64'hF0, 1);
        run_op(1, 1, "SLTU8", SLTU, 64'hFF, 64'h01, 64'd0, 1);
        run_op(1, 1, "MUL8", MUL, 64'd15, 64'd17, 64'd255, 9);
        run_op(1, 1, "DIV8 ovf", DIV, 64'h80, 64'hFF, 64'h80, 1);
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [63:0] a, b;
            op = 4'($urandom);
            a  = rnd_operand() & 64'hFF;
            b  = rnd_operand() & 64'hFF;
            run_op(1, 0, "rand8", op, a, b, ref_alu(op, a, b, 8), ref_lat(op, a, b, 8));
        end

        // Randomised traffic on the 64-bit instance, checked every cycle by the tracker
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            ALUControl = 4'($urandom);
            X          = rnd_operand();
            Y          = rnd_operand();
            flush      = ($urandom_range(0, 199) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (80) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked successor to the combinational 64-bit ALU.
- Keeps the existing ALUControl encodings and the Zero flag.
- Adds shift, compare, XOR, and iterative multiply/divide/remainder ops (RV64M-style semantics).
- Sits between decode and writeback of the multi-cycle datapath. The core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥8 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from Y[SHAMT_W-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an op.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B / divisor / shift amount.
- ALUControl  in  4  operation select.
- flush  in  1  synchronous abort of any op in flight.
- out_valid  out  1  ALUResult/Zero valid.
- out_ready  in  1  consumer takes the result.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  registered; 1 when ALUResult == 0.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (unchanged).
  - 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 MUL (low WIDTH bits), 1100 DIVU, 1101 REMU, 1110 DIV, 1111 REM.
  - 1011 is reserved: returns 0 with Zero=1 and latency 1.
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=0, counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid with a simple op (not MUL/DIV/REM), compute and register the result, then go to DONE. On in_valid with MUL/DIV/REM, latch operands and go to BUSY.
  - BUSY: in_ready=0. One radix-2 step per cycle for WIDTH cycles, then load the result register and go to DONE.
  - DONE: out_valid=1; ALUResult and Zero held stable. On out_ready, go to IDLE. No new op is accepted in DONE, even when out_ready=1.
- Latency from the accepting edge to out_valid:
  - simple ops: 1 cycle.
  - MUL/DIV/REM: WIDTH+1 cycles.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU return 0 or 1, zero-extended.
  - Shifts use only the low SHAMT_W bits of Y.
- MUL: shift-add over unsigned magnitudes; low WIDTH bits are identical for signed and unsigned.
- DIV/REM: restoring division on magnitudes. Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
- Divide by zero (Y==0): no iteration, latency 1. DIV/DIVU return all ones; REM/REMU return X.
- Signed overflow (X = most-negative, Y = -1): latency 1. DIV returns X; REM returns 0.
- flush=1:
  - In BUSY or DONE: go to IDLE next cycle, out_valid=0, result discarded.
  - In IDLE: blocks acceptance that cycle.
  - flush has priority over in_valid and out_ready.
- Reset mid-operation: immediate return to reset values; the partial result is lost.
- Inputs X, Y, ALUControl are sampled only at acceptance. Later changes have no effect.

Decomposition:
- alu_pkg holds:
  - localparams for all 16 ALUControl codes.
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - an is_iterative(op) function.
- One sub-module, muldiv_iter:
  - ports: start, op, a, b, busy, done, result.
  - contains the WIDTH-step counter, the shift-add multiplier and the restoring divider.
  - the parent FSM keeps the simple-op datapath and the handshake.

Test Plan:
- Regression: each with out_ready=1, out_valid must rise 1 cycle after acceptance.
  - 7 AND 4 → 4, Zero=0.
  - 7 OR 8 → 15.
  - 10 ADD 23 → 33.
  - 15 SUB 18 → -3 (0xFFFF_FFFF_FFFF_FFFD).
  - 5 SUB 5 → 0, Zero=1.
- Iterative ops, WIDTH=64: out_valid must rise exactly 65 cycles after acceptance, with in_ready=0 throughout.
  - MUL 6×7 → 42.
  - DIV -7/2 → -3.
  - REM -7/2 → -1.
  - DIVU 100/7 → 14.
- Divide corner cases: each must give out_valid after 1 cycle.
  - DIVU 9/0 → all ones.
  - REM 9/0 → 9.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
- Backpressure:
  - hold out_ready=0 for 10 cycles after ADD 1+1 → out_valid stays 1, ALUResult stays 2, in_ready stays 0.
  - then out_ready=1 → IDLE next cycle.
- Flush and reset:
  - flush at cycle 20 of a DIV → IDLE next cycle, no out_valid pulse.
  - a following SLL 1<<63 → 0x8000_0000_0000_0000.
  - rst_n low mid-MUL → outputs return to reset values asynchronously.
- Parametrisation, WIDTH=8:
  - SRA 0x80>>3 → 0xF0; SLTU 0xFF<0x01 → 0.
  - MUL 15×17 → 255 with out_valid after 9 cycles.
